param_cpu: RTL

Parametrised single-cycle-per-phase accumulator processor combining control unit and datapath in one block, the next generation of our 8-bit CU+DP processor. Data width and memory depth are generics. A program-load/debug port gives the bench or a host direct access to memory. An optional overflow trap halts the machine on signed arithmetic overflow.

---
 rtl/param_cpu.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/param_cpu.sv
// Parametrised accumulator processor: control unit, datapath and memory in one block,
// with a program/debug port. Optional overflow trap is enabled by defining PROC_OVF_EN.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_FETCH   | latch opcode/address from M[PC], advance PC
// S_DECODE  | route to EXEC, IN_WAIT or HALT by opcode
// S_EXEC    | LOAD/STORE/ADD/SUB/JZ/JPOS, back to FETCH (or HALT on trap)
// S_IN_WAIT | wait for enter high, then load A from dataIn
// S_IN_REL  | wait for enter low so one press loads exactly once
// S_HALT    | absorbing until reset; program port writable here
module param_cpu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enter,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] dataOut,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        IR,
  output logic              Halt,
  output logic              ovf
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_IN_WAIT,
    S_IN_REL,
    S_HALT
  } state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_acc;
  logic [ADDR_W-1:0] r_pc;
  logic [2:0]        r_ir_op;
  logic [ADDR_W-1:0] r_ir_addr;
  state_t            r_state;
  logic              r_halt;

  logic [DATA_W-1:0] w_mop;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic              w_prog_ok;
  logic              w_store;

  assign w_mop     = r_mem[r_ir_addr];
  assign w_sum     = r_acc + w_mop;
  assign w_diff    = r_acc - w_mop;
  // Program writes only while held in reset or halted, so they never race a STORE.
  assign w_prog_ok = prog_we && (!reset || (r_state == S_HALT));
  assign w_store   = reset && (r_state == S_EXEC) && (r_ir_op == OP_STORE);

  assign dbg_data = r_mem[prog_addr];
  assign dataOut  = r_acc;
  assign pc       = r_pc;
  assign IR       = r_ir_op;
  assign Halt     = r_halt;

`ifdef PROC_OVF_EN
  logic r_ovf;
  logic w_add_ovf;
  logic w_sub_ovf;

  assign w_add_ovf = (r_acc[DATA_W-1] == w_mop[DATA_W-1]) && (w_sum[DATA_W-1] != r_acc[DATA_W-1]);
  assign w_sub_ovf = (r_acc[DATA_W-1] != w_mop[DATA_W-1]) && (w_diff[DATA_W-1] != r_acc[DATA_W-1]);
  assign ovf       = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (w_prog_ok) begin
      r_mem[prog_addr] <= prog_data;
    end else if (w_store) begin
      r_mem[r_ir_addr] <= r_acc;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_acc     <= '0;
      r_pc      <= '0;
      r_ir_op   <= '0;
      r_ir_addr <= '0;
      r_halt    <= 1'b0;
      r_state   <= S_FETCH;
`ifdef PROC_OVF_EN
      r_ovf     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH: begin
          r_ir_op   <= r_mem[r_pc][DATA_W-1 -: 3];
          r_ir_addr <= r_mem[r_pc][ADDR_W-1:0];
          r_pc      <= r_pc + 1'b1;
          r_state   <= S_DECODE;
        end
        S_DECODE: begin
          case (r_ir_op)
            OP_IN:   r_state <= S_IN_WAIT;
            OP_HALT: begin
              r_state <= S_HALT;
              r_halt  <= 1'b1;
            end
            default: r_state <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          r_state <= S_FETCH;
          case (r_ir_op)
            OP_LOAD: r_acc <= w_mop;
            OP_ADD: begin
              r_acc <= w_sum;
`ifdef PROC_OVF_EN
              if (w_add_ovf) begin
                r_ovf   <= 1'b1;
                r_halt  <= 1'b1;
                r_state <= S_HALT;
              end
`endif
            end
            OP_SUB: begin
              r_acc <= w_diff;
`ifdef PROC_OVF_EN
              if (w_sub_ovf) begin
                r_ovf   <= 1'b1;
                r_halt  <= 1'b1;
                r_state <= S_HALT;
              end
`endif
            end
            OP_JZ: begin
              if (r_acc == '0) r_pc <= r_ir_addr;
            end
            OP_JPOS: begin
              if (!r_acc[DATA_W-1] && (r_acc != '0)) r_pc <= r_ir_addr;
            end
            default: ;
          endcase
        end
        S_IN_WAIT: begin
          if (enter) begin
            r_acc   <= dataIn;
            r_state <= S_IN_REL;
          end
        end
        S_IN_REL: begin
          if (!enter) r_state <= S_FETCH;
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule
